// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream and command-beat signals of uart_cmd_decoder.
// master: the decoder (pulls bytes from the UART, drives command beats).
// slave:  the surrounding logic (UART RX byte holder and register-write sink).
interface uart_cmd_decoder_if;
    // UART RX byte handshake
    logic       rx_ready;
    logic       read_valid;
    logic [7:0] read_data;
    logic       read_strobe;

    // Register-write command beats
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_last;

    modport master (
        input  rx_ready, read_valid, read_data, cmd_ready,
        output read_strobe, cmd_valid, cmd_addr, cmd_data, cmd_last
    );

    modport slave (
        output rx_ready, read_valid, read_data, cmd_ready,
        input  read_strobe, cmd_valid, cmd_addr, cmd_data, cmd_last
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: pulls bytes from a UART RX holder, parses framed write
// commands (SYNC, ADDR, LEN, payload, CSUM), buffers the payload and replays
// it as address/data beats once the checksum is verified.
// Optional feature: define UART_CMD_TIMEOUT_EN to reject frames whose
// inter-byte gap reaches TIMEOUT_CYCLES.
module uart_cmd_decoder #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 2080
) (
    input  logic                clk,
    input  logic                reset,
    uart_cmd_decoder_if.master  bus,
    output logic                frame_err,
    output logic [7:0]          err_count,
    output logic                busy
);

    localparam int IW = $clog2(MAX_LEN + 1);                    // length/index width
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;    // buffer address width

    typedef enum logic {F_IDLE, F_WAIT} fetch_t;
    typedef enum logic [2:0] {P_HUNT, P_ADDR, P_LEN, P_PAYLOAD, P_CSUM, P_DRAIN} parse_t;

    fetch_t        fstate, fstate_nxt;
    logic          strobe_nxt;
    parse_t        pstate, pstate_nxt;

    logic [7:0]    base, base_nxt;
    logic [IW-1:0] len_q, len_nxt;
    logic [IW-1:0] idx, idx_nxt, idx_inc;
    logic [7:0]    sum, sum_nxt, sum_add;
    logic          cmd_valid_nxt, cmd_last_nxt;
    logic [7:0]    cmd_addr_nxt, cmd_data_nxt;
    logic          frame_err_nxt;
    logic [7:0]    err_count_nxt;
    logic          reject, wr_en, timeout;

    logic [7:0]    buffer [MAX_LEN];

    logic          byte_stb;
    logic [7:0]    rx_byte;

    assign byte_stb = (fstate == F_WAIT) && bus.read_valid;
    assign rx_byte  = bus.read_data;
    assign sum_add  = sum + rx_byte;
    assign idx_inc  = idx + 1'b1;
    assign busy     = (pstate != P_HUNT);

    // Fetch FSM state and registered read strobe.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            fstate          <= F_IDLE;
            bus.read_strobe <= 1'b0;
        end else begin
            fstate          <= fstate_nxt;
            bus.read_strobe <= strobe_nxt;
        end
    end

    // Fetch FSM next state: request one byte, then wait for it to arrive.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fstate_nxt = fstate;
        strobe_nxt = 1'b0;
        case (fstate)
            F_IDLE: begin
                // Holding off during DRAIN leaves the byte parked in the UART.
                if (bus.rx_ready && (pstate != P_DRAIN)) begin
                    strobe_nxt = 1'b1;
                    fstate_nxt = F_WAIT;
                end
            end
            F_WAIT: begin
                if (bus.read_valid) fstate_nxt = F_IDLE;
            end
            default: fstate_nxt = F_IDLE;
        endcase
    end

`ifdef UART_CMD_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    logic [GW-1:0] gap;
    logic          gap_run;

    assign gap_run = (pstate == P_ADDR) || (pstate == P_LEN) ||
                     (pstate == P_PAYLOAD) || (pstate == P_CSUM);
    assign timeout = gap_run && !byte_stb && (gap == GW'(TIMEOUT_CYCLES - 1));

    // Inter-byte gap counter, live only while a frame is partially received.
    always_ff @(posedge clk) begin
        if (reset || byte_stb || !gap_run || timeout) gap <= '0;
        else                                          gap <= gap + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // Parser state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pstate        <= P_HUNT;
            base          <= '0;
            len_q         <= '0;
            idx           <= '0;
            sum           <= '0;
            bus.cmd_valid <= 1'b0;
            bus.cmd_addr  <= '0;
            bus.cmd_data  <= '0;
            bus.cmd_last  <= 1'b0;
            frame_err     <= 1'b0;
            err_count     <= '0;
        end else begin
            pstate        <= pstate_nxt;
            base          <= base_nxt;
            len_q         <= len_nxt;
            idx           <= idx_nxt;
            sum           <= sum_nxt;
            bus.cmd_valid <= cmd_valid_nxt;
            bus.cmd_addr  <= cmd_addr_nxt;
            bus.cmd_data  <= cmd_data_nxt;
            bus.cmd_last  <= cmd_last_nxt;
            frame_err     <= frame_err_nxt;
            err_count     <= err_count_nxt;
        end
    end

    // Payload storage write port.
    // NOTE: the buffer has no reset; it is only read after a full frame refills it.
    always_ff @(posedge clk) begin
        if (wr_en) buffer[idx[AW-1:0]] <= rx_byte;
    end

    // Parser next state: frame parsing, checksum verify and beat replay.
    always_comb begin
        pstate_nxt    = pstate;
        base_nxt      = base;
        len_nxt       = len_q;
        idx_nxt       = idx;
        sum_nxt       = sum;
        cmd_valid_nxt = bus.cmd_valid;
        cmd_addr_nxt  = bus.cmd_addr;
        cmd_data_nxt  = bus.cmd_data;
        cmd_last_nxt  = bus.cmd_last;
        frame_err_nxt = 1'b0;
        err_count_nxt = err_count;
        reject        = 1'b0;
        wr_en         = 1'b0;

        case (pstate)
            P_HUNT: begin
                if (byte_stb && (rx_byte == SYNC_BYTE)) pstate_nxt = P_ADDR;
            end
            P_ADDR: begin
                if (byte_stb) begin
                    base_nxt   = rx_byte;
                    sum_nxt    = rx_byte;
                    pstate_nxt = P_LEN;
                end
            end
            P_LEN: begin
                if (byte_stb) begin
                    if ((rx_byte == 8'h00) || (rx_byte > 8'(MAX_LEN))) begin
                        reject = 1'b1;
                    end else begin
                        len_nxt    = IW'(rx_byte);
                        sum_nxt    = sum_add;
                        idx_nxt    = '0;
                        pstate_nxt = P_PAYLOAD;
                    end
                end
            end
            P_PAYLOAD: begin
                if (byte_stb) begin
                    wr_en   = 1'b1;
                    sum_nxt = sum_add;
                    if (idx == len_q - 1'b1) pstate_nxt = P_CSUM;
                    else                     idx_nxt    = idx_inc;
                end
            end
            P_CSUM: begin
                if (byte_stb) begin
                    if (sum_add == 8'h00) begin
                        // Present beat 0 immediately so DRAIN starts at full rate.
                        pstate_nxt    = P_DRAIN;
                        idx_nxt       = '0;
                        cmd_valid_nxt = 1'b1;
                        cmd_addr_nxt  = base;
                        cmd_data_nxt  = buffer[0];
                        cmd_last_nxt  = (len_q == IW'(1));
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            P_DRAIN: begin
                // Beat registers only move on a handshake, so a stalled beat holds.
                if (bus.cmd_valid && bus.cmd_ready) begin
                    if (bus.cmd_last) begin
                        cmd_valid_nxt = 1'b0;
                        cmd_last_nxt  = 1'b0;
                        pstate_nxt    = P_HUNT;
                    end else begin
                        idx_nxt      = idx_inc;
                        cmd_addr_nxt = bus.cmd_addr + 8'h01;
                        cmd_data_nxt = buffer[idx_inc[AW-1:0]];
                        cmd_last_nxt = (idx_inc == len_q - 1'b1);
                    end
                end
            end
            default: pstate_nxt = P_HUNT;
        endcase

        if (timeout) reject = 1'b1;

        if (reject) begin
            pstate_nxt    = P_HUNT;
            frame_err_nxt = 1'b1;
            if (err_count != 8'hFF) err_count_nxt = err_count + 8'h01;
        end
    end

endmodule
